// File: rtl/sum_acc_pkg.sv
// Shared types and default sizing for the block-sum accumulator.
`timescale 1ns/1ps
package sum_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 9;
    localparam int DEF_COUNT  = 8;

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates COUNT unsigned adder sums per block, tracking the running max,
// and holds the block result until the downstream handshake completes.
`timescale 1ns/1ps
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COUNT  = DEF_COUNT,
    parameter int ACC_W  = DATA_W + $clog2(COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_sum,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_total,
    output logic [DATA_W-1:0] out_max,
    output logic              busy
);

    localparam int              CNT_W = $clog2(COUNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic              in_ready_q, out_valid_q, busy_q;
    logic              beat;

    assign beat = in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    max_d   = '0;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    acc_d = acc_q + ACC_W'(in_sum);
                    cnt_d = cnt_q + CNT_W'(1);
                    max_d = (in_sum > max_q) ? in_sum : max_q;
                    if (cnt_q == LAST) state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides everything, including a beat or start this cycle.
        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            max_d   = '0;
        end
    end

    // Handshake/status flags are registered from the next state so they
    // line up with state_q without any combinational decode on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            max_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            in_ready_q  <= (state_d == ST_ACCUM);
            out_valid_q <= (state_d == ST_HOLD);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_total = acc_q;
    assign out_max   = max_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench: two instances (COUNT=4 and COUNT=8) driven on the falling edge.
`timescale 1ns/1ps
module tb_sum_accumulator;

    typedef struct {
        logic [11:0] tot;
        logic [8:0]  mx;
    } exp_t;

    logic        clk, rst_n;
    logic        start_a, clear_a, inv_a, inrdy_a, outv_a, outrdy_a, busy_a;
    logic [8:0]  insum_a, max_a;
    logic [10:0] tot_a;
    logic        start_b, clear_b, inv_b, inrdy_b, outv_b, outrdy_b, busy_b;
    logic [8:0]  insum_b, max_b;
    logic [11:0] tot_b;

    exp_t sb_a[$];
    exp_t sb_b[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    sum_accumulator #(.DATA_W(9), .COUNT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .clear(clear_a),
        .in_valid(inv_a), .in_sum(insum_a), .in_ready(inrdy_a),
        .out_valid(outv_a), .out_ready(outrdy_a), .out_total(tot_a),
        .out_max(max_a), .busy(busy_a)
    );

    sum_accumulator #(.DATA_W(9), .COUNT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .clear(clear_b),
        .in_valid(inv_b), .in_sum(insum_b), .in_ready(inrdy_b),
        .out_valid(outv_b), .out_ready(outrdy_b), .out_total(tot_b),
        .out_max(max_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Tasks enter and leave on a falling edge; inputs driven here are taken
    // on the next rising edge.
    task automatic do_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic beat_a(input logic [8:0] v);
        inv_a   = 1'b1;
        insum_a = v;
        @(negedge clk);
        inv_a   = 1'b0;
    endtask

    task automatic handshake_a();
        outrdy_a = 1'b1;
        @(negedge clk);
        outrdy_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++; if (inrdy_a !== 1'b0) $display("FAIL reset_in_ready got=%0b exp=0", inrdy_a); else pass_cnt++;
        chk_cnt++; if (outv_a !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", outv_a); else pass_cnt++;
        chk_cnt++; if (busy_a !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy_a); else pass_cnt++;
        chk_cnt++; if (tot_a !== 11'd0) $display("FAIL reset_total got=%0d exp=0", tot_a); else pass_cnt++;
        chk_cnt++; if (max_a !== 9'd0) $display("FAIL reset_max got=%0d exp=0", max_a); else pass_cnt++;
        chk_cnt++; if (busy_b !== 1'b0) $display("FAIL reset_busy_b got=%0b exp=0", busy_b); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [8:0] vals [4];
        exp_t e;
        vals = '{9'd25, 9'd150, 9'd250, 9'd510};
        outrdy_a = 1'b0;
        do_start_a();
        chk_cnt++; if (busy_a !== 1'b1) $display("FAIL b2b_busy got=%0b exp=1", busy_a); else pass_cnt++;
        chk_cnt++; if (inrdy_a !== 1'b1) $display("FAIL b2b_in_ready got=%0b exp=1", inrdy_a); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sb_a.push_back('{tot: 12'd935, mx: 9'd510});
            inv_a   = 1'b1;
            insum_a = vals[i];
            @(negedge clk);
        end
        inv_a = 1'b0;
        chk_cnt++; if (outv_a !== 1'b1) $display("FAIL b2b_latency out_valid got=%0b exp=1", outv_a); else pass_cnt++;
        chk_cnt++; if (inrdy_a !== 1'b0) $display("FAIL b2b_hold_in_ready got=%0b exp=0", inrdy_a); else pass_cnt++;
        chk_cnt++;
        if (sb_a.size() == 0) $display("FAIL b2b_scoreboard empty");
        else begin
            e = sb_a.pop_front();
            if ({1'b0, tot_a} !== e.tot || max_a !== e.mx)
                $display("FAIL b2b_result got=%0d/%0d exp=%0d/%0d", tot_a, max_a, e.tot, e.mx);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold_stall();
        // Block from test_back_to_back is parked in HOLD; start must be ignored.
        start_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (outv_a !== 1'b1 || inrdy_a !== 1'b0 || tot_a !== 11'd935 || max_a !== 9'd510)
                $display("FAIL stall_cycle%0d got v=%0b r=%0b tot=%0d max=%0d exp v=1 r=0 tot=935 max=510",
                         i, outv_a, inrdy_a, tot_a, max_a);
            else pass_cnt++;
        end
        outrdy_a = 1'b1;
        @(negedge clk);
        outrdy_a = 1'b0;
        start_a  = 1'b0;
        chk_cnt++; if (outv_a !== 1'b0) $display("FAIL stall_release out_valid got=%0b exp=0", outv_a); else pass_cnt++;
        chk_cnt++; if (busy_a !== 1'b0) $display("FAIL stall_release busy got=%0b exp=0", busy_a); else pass_cnt++;
        chk_cnt++; if (tot_a !== 11'd935) $display("FAIL idle_retain total got=%0d exp=935", tot_a); else pass_cnt++;
    endtask

    task automatic test_gapped();
        exp_t e;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        sb_b.push_back('{tot: 12'd4080, mx: 9'd510});
        for (int i = 0; i < 16; i++) begin
            inv_b   = (i % 2 == 0);
            insum_b = 9'd510;
            @(negedge clk);
        end
        inv_b = 1'b0;
        for (int k = 0; k < 20 && !outv_b; k++) @(negedge clk);
        chk_cnt++; if (outv_b !== 1'b1) $display("FAIL gapped_timeout out_valid got=%0b exp=1", outv_b); else pass_cnt++;
        chk_cnt++;
        if (sb_b.size() == 0) $display("FAIL gapped_scoreboard empty");
        else begin
            e = sb_b.pop_front();
            if (tot_b !== e.tot || max_b !== e.mx)
                $display("FAIL gapped_result got=%0d/%0d exp=%0d/%0d", tot_b, max_b, e.tot, e.mx);
            else pass_cnt++;
        end
        outrdy_b = 1'b1;
        @(negedge clk);
        outrdy_b = 1'b0;
        chk_cnt++; if (busy_b !== 1'b0) $display("FAIL gapped_idle busy got=%0b exp=0", busy_b); else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        exp_t e;
        start_a = 1'b1;
        @(negedge clk);
        // start stays high through ACCUM; a restart would lose the early beats
        beat_a(9'd3);
        beat_a(9'd4);
        beat_a(9'd5);
        sb_a.push_back('{tot: 12'd18, mx: 9'd6});
        beat_a(9'd6);
        start_a = 1'b0;
        chk_cnt++; if (outv_a !== 1'b1) $display("FAIL noreset_out_valid got=%0b exp=1", outv_a); else pass_cnt++;
        chk_cnt++;
        if (sb_a.size() == 0) $display("FAIL noreset_scoreboard empty");
        else begin
            e = sb_a.pop_front();
            if ({1'b0, tot_a} !== e.tot || max_a !== e.mx)
                $display("FAIL noreset_result got=%0d/%0d exp=%0d/%0d", tot_a, max_a, e.tot, e.mx);
            else pass_cnt++;
        end
        handshake_a();
    endtask

    task automatic test_clear();
        do_start_a();
        beat_a(9'd5);
        beat_a(9'd6);
        inv_a   = 1'b1;
        insum_a = 9'd7;
        clear_a = 1'b1;
        @(negedge clk);
        inv_a   = 1'b0;
        clear_a = 1'b0;
        chk_cnt++;
        if (busy_a !== 1'b0 || inrdy_a !== 1'b0 || outv_a !== 1'b0)
            $display("FAIL clear_state got busy=%0b r=%0b v=%0b exp 0/0/0", busy_a, inrdy_a, outv_a);
        else pass_cnt++;
        chk_cnt++; if (tot_a !== 11'd0) $display("FAIL clear_total got=%0d exp=0", tot_a); else pass_cnt++;
        chk_cnt++; if (max_a !== 9'd0) $display("FAIL clear_max got=%0d exp=0", max_a); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (busy_a !== 1'b0) $display("FAIL clear_stays_idle busy got=%0b exp=0", busy_a); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_start_a();
        beat_a(9'd100);
        beat_a(9'd100);
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (tot_a !== 11'd0 || max_a !== 9'd0 || busy_a !== 1'b0 || inrdy_a !== 1'b0 || outv_a !== 1'b0)
            $display("FAIL async_reset got tot=%0d max=%0d busy=%0b r=%0b v=%0b exp all 0",
                     tot_a, max_a, busy_a, inrdy_a, outv_a);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (busy_a !== 1'b0 || outv_a !== 1'b0)
            $display("FAIL post_reset_idle got busy=%0b v=%0b exp 0/0", busy_a, outv_a);
        else pass_cnt++;
        do_start_a();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sb_a.push_back('{tot: 12'd40, mx: 9'd10});
            beat_a(9'd10);
        end
        chk_cnt++; if (outv_a !== 1'b1) $display("FAIL post_reset_out_valid got=%0b exp=1", outv_a); else pass_cnt++;
        chk_cnt++;
        if (sb_a.size() == 0) $display("FAIL post_reset_scoreboard empty");
        else begin
            e = sb_a.pop_front();
            if ({1'b0, tot_a} !== e.tot || max_a !== e.mx)
                $display("FAIL post_reset_result got=%0d/%0d exp=%0d/%0d", tot_a, max_a, e.tot, e.mx);
            else pass_cnt++;
        end
        handshake_a();
    endtask

    task automatic test_all_ones();
        exp_t e;
        do_start_a();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sb_a.push_back('{tot: 12'd2044, mx: 9'd511});
            beat_a(9'h1FF);
        end
        chk_cnt++; if (outv_a !== 1'b1) $display("FAIL ones_out_valid got=%0b exp=1", outv_a); else pass_cnt++;
        chk_cnt++;
        if (sb_a.size() == 0) $display("FAIL ones_scoreboard empty");
        else begin
            e = sb_a.pop_front();
            if ({1'b0, tot_a} !== e.tot || max_a !== e.mx)
                $display("FAIL ones_result got=%0d/%0d exp=%0d/%0d", tot_a, max_a, e.tot, e.mx);
            else pass_cnt++;
        end
        handshake_a();
    endtask

    task automatic test_start_clear();
        start_a = 1'b1;
        clear_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        clear_a = 1'b0;
        chk_cnt++;
        if (busy_a !== 1'b0 || inrdy_a !== 1'b0)
            $display("FAIL start_clear got busy=%0b r=%0b exp 0/0", busy_a, inrdy_a);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (busy_a !== 1'b0) $display("FAIL start_clear_idle busy got=%0b exp=0", busy_a); else pass_cnt++;
    endtask

    initial begin
        rst_n    = 1'b0;
        start_a  = 1'b0; clear_a = 1'b0; inv_a = 1'b0; insum_a = '0; outrdy_a = 1'b0;
        start_b  = 1'b0; clear_b = 1'b0; inv_b = 1'b0; insum_b = '0; outrdy_b = 1'b0;
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_hold_stall();
        test_gapped();
        test_start_ignored();
        test_clear();
        test_reset_mid();
        test_all_ones();
        test_start_clear();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter DATA_W, default 9, width of each incoming adder sum.
REQ-002 Parameter COUNT, default 8, sums per block; legal range 2..256.
REQ-003 Parameter ACC_W, default DATA_W+$clog2(COUNT), accumulator width; overflow impossible by construction.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begins a new block; sampled only in IDLE.
REQ-007 clear  input  1  synchronous abort to IDLE; accepted in any state.
REQ-008 in_valid  input  1  upstream sum present.
REQ-009 in_sum  input  DATA_W  unsigned sum from the adder stage.
REQ-010 in_ready  output  1  block accepts in_sum this cycle.
REQ-011 out_valid  output  1  block result available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_total  output  ACC_W  unsigned sum of the COUNT accepted samples.
REQ-014 out_max  output  DATA_W  largest accepted sample in the block.
REQ-015 busy  output  1  high in ACCUM and HOLD.

Function
REQ-016 FSM states IDLE, ACCUM, HOLD; all outputs registered or decoded from state only.
REQ-017 IDLE: in_ready=0, out_valid=0; start=1 and clear=0 -> clear acc, count, max; ACCUM next cycle.
REQ-018 ACCUM: in_ready=1; beat = in_valid && in_ready; each beat acc += in_sum (zero-extended), count++, max = greater of max and in_sum.
REQ-019 No beat -> acc, count, max hold; in_valid gaps of any length allowed.
REQ-020 COUNT-th beat -> HOLD on same edge; out_valid=1 in the following cycle (1-cycle latency from final beat).
REQ-021 HOLD: in_ready=0, out_valid=1, out_total/out_max stable until handshake.
REQ-022 HOLD with out_ready=1 -> IDLE next cycle, out_valid=0; out_ready low holds HOLD indefinitely.
REQ-023 out_total and out_max retain last block values in IDLE until next start.
REQ-024 start ignored in ACCUM and HOLD.
REQ-025 clear=1 in any state -> IDLE next cycle, acc/count/max/out_total/out_max zeroed; beat in same cycle discarded.
REQ-026 clear and start asserted together in IDLE: clear wins, remains IDLE.
REQ-027 in_sum all-ones for all COUNT beats yields out_total = COUNT*(2^DATA_W-1) exactly.

Reset
REQ-028 rst_n low asynchronously forces IDLE, acc=0, count=0, out_total=0, out_max=0, out_valid=0, in_ready=0, busy=0.
REQ-029 Reset asserted mid-ACCUM or mid-HOLD discards the partial or pending block; no output after release until a new start.
REQ-030 Release synchronous to clk; first start honoured on first rising edge after rst_n high.

Structure
REQ-031 Package sum_acc_pkg holds state enum type and default DATA_W/COUNT constants.
REQ-032 Single module, no sub-modules; count register width $clog2(COUNT+1).

Verification
REQ-033 COUNT=4; start; sums 25,150,250,510 back-to-back -> out_valid one cycle after 4th beat, out_total=935, out_max=510.
REQ-034 COUNT=8; eight sums of 510 with in_valid low alternate cycles -> out_total=4080, out_max=510, no overflow.
REQ-035 Block complete, out_ready low 5 cycles -> out_valid and outputs stable 5 cycles, in_ready=0; out_ready high -> IDLE next cycle.
REQ-036 rst_n low after 2 of 4 beats -> all outputs 0 immediately; new start then 4 sums of 10 -> out_total=40, no residue.
REQ-037 clear with in_valid high on 3rd beat -> beat discarded, IDLE, out_total=0; start during ACCUM produces no restart.
REQ-038 start and clear high together in IDLE -> state remains IDLE, busy=0.
